demux_1to4_8bit_buf: RTL and testbench

Buffered 1-to-4 8-bit demultiplexer: the write-side counterpart of the 4-to-1 8-bit mux. It accepts one 8-bit word per handshake and routes it, by a 2-bit select, into one of four one-entry output slots. Each slot holds its word until the consumer acknowledges it. A broadcast mode writes all four slots at once. The block sits between the datapath result bus and the register/peripheral destinations that the processor fans out to.

---
 rtl/demux_1to4_8bit_buf_pkg.sv | 13 +
 rtl/demux_1to4_8bit_buf_slot.sv | 42 ++++
 rtl/demux_1to4_8bit_buf.sv | 49 ++++
 tb/tb_demux_1to4_8bit_buf.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/demux_1to4_8bit_buf_pkg.sv
// Shared constants for the buffered 1-to-4 demultiplexer and its slots.
package demux_1to4_8bit_buf_pkg;
    localparam int DEMUX_W   = 8;
    localparam int NUM_SLOTS = 4;

    localparam logic [1:0] SLOT0 = 2'd0;
    localparam logic [1:0] SLOT1 = 2'd1;
    localparam logic [1:0] SLOT2 = 2'd2;
    localparam logic [1:0] SLOT3 = 2'd3;

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;
endpackage

// File: rtl/demux_1to4_8bit_buf_slot.sv
// One output slot: a data register plus a two-state EMPTY/FULL handshake FSM.
module demux_slot
    import demux_1to4_8bit_buf_pkg::*;
#(
    parameter int WIDTH = DEMUX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic             ack,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             free
);
    logic state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            q       <= '0;
        end else begin
            state_q <= state_d;
            if (wr) q <= d;
        end
    end

    // A write wins over a same-cycle ack so the replacement word stays pending.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (wr) state_d = ST_FULL;
            ST_FULL:  if (!wr && ack) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        valid = (state_q == ST_FULL);
        free  = !valid || ack;
    end
endmodule

// File: rtl/demux_1to4_8bit_buf.sv
// Buffered 1-to-4 demux: routes one word per handshake into one slot, or all four on broadcast.
module demux_1to4_8bit_buf
    import demux_1to4_8bit_buf_pkg::*;
#(
    parameter int WIDTH = DEMUX_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           S,
    input  logic                 bcast,
    input  logic [WIDTH-1:0]     D,
    output logic [WIDTH-1:0]     Q0,
    output logic [WIDTH-1:0]     Q1,
    output logic [WIDTH-1:0]     Q2,
    output logic [WIDTH-1:0]     Q3,
    output logic [NUM_SLOTS-1:0] q_valid,
    input  logic [NUM_SLOTS-1:0] q_ack
);
    logic [NUM_SLOTS-1:0]            free;
    logic [NUM_SLOTS-1:0]            wr;
    logic [NUM_SLOTS-1:0][WIDTH-1:0] q_arr;
    logic                            accept;

    // Ready depends only on slot state and acks, never on in_valid.
    assign in_ready = bcast ? (&free) : free[S];
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
        assign wr[k] = accept && (bcast || (S == 2'(k)));

        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .wr    (wr[k]),
            .ack   (q_ack[k]),
            .d     (D),
            .q     (q_arr[k]),
            .valid (q_valid[k]),
            .free  (free[k])
        );
    end

    assign Q0 = q_arr[SLOT0];
    assign Q1 = q_arr[SLOT1];
    assign Q2 = q_arr[SLOT2];
    assign Q3 = q_arr[SLOT3];
endmodule

// File: tb/tb_demux_1to4_8bit_buf.sv
// Directed bench for demux_1to4_8bit_buf with hand-computed expectations.
module tb_demux_1to4_8bit_buf;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, bcast;
    logic [1:0] S;
    logic [7:0] D, Q0, Q1, Q2, Q3;
    logic [3:0] q_valid, q_ack;

    int n_vec = 0;
    int n_bad = 0;

    demux_1to4_8bit_buf #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .S(S), .bcast(bcast), .D(D), .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3),
        .q_valid(q_valid), .q_ack(q_ack)
    );

    always #5 clk = ~clk;

    // Producer must hold D/S/bcast steady across a stall.
    logic       prv_stall = 1'b0;
    logic [7:0] prv_d;
    logic [1:0] prv_s;
    logic       prv_b;
    always @(posedge clk) begin
        if (rst_n && prv_stall && in_valid)
            assert (D == prv_d && S == prv_s && bcast == prv_b)
                else $error("producer changed inputs during stall");
        prv_stall <= rst_n && in_valid && !in_ready;
        prv_d     <= D;
        prv_s     <= S;
        prv_b     <= bcast;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; bcast = 1'b0; S = 2'd0; D = 8'h00; q_ack = 4'b0000;
        #2;
        chk("rst_qv", 32'(q_valid), 32'h0);
        chk("rst_q", {Q3, Q2, Q1, Q0}, 32'h0);
        chk("rst_rdy", 32'(in_ready), 32'h1);
        tick(); tick();
        rst_n = 1'b1;

        // single write to slot 2
        in_valid = 1'b1; S = 2'd2; D = 8'hA5;
        #1 chk("w2_rdy", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        chk("w2_q2", 32'(Q2), 32'hA5);
        chk("w2_qv", 32'(q_valid), 32'h4);
        chk("w2_oth", {Q3, Q1, Q0}, 32'h0);
        q_ack = 4'b0100;
        tick();
        q_ack = 4'b0000;
        chk("w2_ack", 32'(q_valid), 32'h0);
        chk("w2_hold", 32'(Q2), 32'hA5);

        // stall on full slot 1
        in_valid = 1'b1; S = 2'd1; D = 8'h11;
        tick();
        D = 8'h22;
        #1 chk("st_rdy0", 32'(in_ready), 32'h0);
        tick();
        chk("st_keep", 32'(Q1), 32'h11);
        chk("st_qv", 32'(q_valid), 32'h2);
        q_ack = 4'b0010;
        #1 chk("st_rdy1", 32'(in_ready), 32'h1);
        tick();
        chk("st_new", 32'(Q1), 32'h22);
        chk("st_qv2", 32'(q_valid), 32'h2);
        in_valid = 1'b0;
        q_ack = 4'b0010;
        tick();
        q_ack = 4'b0000;
        chk("st_clr", 32'(q_valid), 32'h0);

        // back-to-back streaming into slot 3 with ack tracking valid
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; S = 2'd3; D = 8'(i);
            q_ack = {q_valid[3], 3'b000};
            #1 chk("str_rdy", 32'(in_ready), 32'h1);
            tick();
            chk("str_q3", 32'(Q3), 32'(i));
            chk("str_v3", 32'(q_valid[3]), 32'h1);
        end
        in_valid = 1'b0;
        q_ack = 4'b1111;
        tick();
        q_ack = 4'b0000;
        chk("str_clr", 32'(q_valid), 32'h0);

        // broadcast gated by full slot 0
        in_valid = 1'b1; S = 2'd0; D = 8'h77;
        tick();
        bcast = 1'b1; S = 2'd2; D = 8'h5A;
        #1 chk("bc_rdy0", 32'(in_ready), 32'h0);
        tick();
        chk("bc_keep", 32'(Q0), 32'h77);
        chk("bc_qv0", 32'(q_valid), 32'h1);
        q_ack = 4'b0001;
        #1 chk("bc_rdy1", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0; bcast = 1'b0; q_ack = 4'b0000;
        chk("bc_q", {Q3, Q2, Q1, Q0}, 32'h5A5A5A5A);
        chk("bc_qv", 32'(q_valid), 32'hF);
        q_ack = 4'b1111;
        tick();
        chk("bc_clr", 32'(q_valid), 32'h0);

        // ack on empty slots: no effect
        tick();
        q_ack = 4'b0000;
        chk("ae_qv", 32'(q_valid), 32'h0);
        chk("ae_q", {Q3, Q2, Q1, Q0}, 32'h5A5A5A5A);

        // fill slots 0 and 2, then reset with a write in flight
        in_valid = 1'b1; S = 2'd0; D = 8'hC3;
        tick();
        S = 2'd2; D = 8'h3C;
        tick();
        chk("rm_fill", 32'(q_valid), 32'h5);
        S = 2'd1; D = 8'h99;
        rst_n = 1'b0;
        #1;
        chk("rm_qv", 32'(q_valid), 32'h0);
        chk("rm_q", {Q3, Q2, Q1, Q0}, 32'h0);
        #3;
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("rm_lost", 32'(q_valid), 32'h0);
        chk("rm_q1", 32'(Q1), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
